msdap_input_loader: RTL

Serial-to-parallel front end for the MSDAP filter datapath. Deserialises a framed, MSB-first 16-bit word stream and writes it into the three memories that the ALU reads: Rj memory (16x8), coefficient memory (512x16) and circular data memory (256x16). After each stored data sample it hands the ALU `current_data_addr` and a one-cycle start pulse. It also detects long runs of zero input and puts the datapath to sleep.

---
 rtl/msdap_input_loader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/msdap_input_loader.sv
// Serial-to-parallel front end for the MSDAP filter datapath.
//
// Assembles framed, MSB-first 16-bit words from a bit-strobed serial stream and
// routes them, in load order, to the Rj memory, the coefficient memory and then
// the circular data memory. Each stored data sample is followed one cycle later
// by a start pulse to the ALU. Long runs of zero data words put the datapath to
// sleep until a nonzero word arrives.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   bit_en, sdata, sframe    serial input (sdata/sframe sampled when bit_en = 1)
//   rj_we/waddr/wdata        Rj memory write port (16 x 8)
//   coeff_we/waddr/wdata     coefficient memory write port (512 x 16)
//   data_we/waddr/wdata      data memory write port (256 x 16, circular)
//   current_data_addr        address of the newest stored sample (to the ALU)
//   sample_valid             one-cycle ALU start pulse
//   sleeping, state          status: 0 LOAD_RJ, 1 LOAD_COEFF, 2 RUN, 3 SLEEP
module msdap_input_loader #(
  parameter int unsigned NUM_RJ      = 16,
  parameter int unsigned NUM_COEFF   = 512,
  parameter int unsigned SLEEP_ZEROS = 800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_en,
  input  logic        sdata,
  input  logic        sframe,
  output logic        rj_we,
  output logic [3:0]  rj_waddr,
  output logic [7:0]  rj_wdata,
  output logic        coeff_we,
  output logic [8:0]  coeff_waddr,
  output logic [15:0] coeff_wdata,
  output logic        data_we,
  output logic [7:0]  data_waddr,
  output logic [15:0] data_wdata,
  output logic [7:0]  current_data_addr,
  output logic        sample_valid,
  output logic        sleeping,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    StLoadRj    = 2'd0,
    StLoadCoeff = 2'd1,
    StRun       = 2'd2,
    StSleep     = 2'd3
  } state_e;

  localparam logic [3:0] RjLast    = 4'(NUM_RJ - 1);
  localparam logic [8:0] CoeffLast = 9'(NUM_COEFF - 1);
  localparam logic [9:0] SleepLast = 10'(SLEEP_ZEROS - 1);

  // Word assembler. Only 15 bits are stored: bit 16 is taken straight from
  // sdata on the completing edge, so the word is never held in the shifter.
  logic [14:0] shift_q;
  logic [4:0]  cnt_q;
  logic        word_done;
  logic [15:0] word;

  assign word_done = bit_en && !sframe && (cnt_q == 5'd15);
  assign word      = {shift_q, sdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (bit_en) begin
      if (sframe) begin
        // A frame marker always restarts the word, discarding any partial one.
        shift_q <= {14'b0, sdata};
        cnt_q   <= 5'd1;
      end else if (cnt_q != 5'd0) begin
        shift_q <= {shift_q[13:0], sdata};
        cnt_q   <= (cnt_q == 5'd15) ? 5'd0 : cnt_q + 5'd1;
      end
    end
  end

  // State machine: decides where each completed word goes.
  state_e     state_q, state_d;
  logic [9:0] zero_cnt_q, zero_cnt_d;
  logic       rj_wr, coeff_wr, data_wr;

  always_comb begin
    state_d    = state_q;
    zero_cnt_d = zero_cnt_q;
    rj_wr      = 1'b0;
    coeff_wr   = 1'b0;
    data_wr    = 1'b0;
    if (word_done) begin
      unique case (state_q)
        StLoadRj: begin
          rj_wr = 1'b1;
          if (rj_waddr == RjLast) state_d = StLoadCoeff;
        end
        StLoadCoeff: begin
          coeff_wr = 1'b1;
          if (coeff_waddr == CoeffLast) state_d = StRun;
        end
        StRun: begin
          data_wr = 1'b1;
          if (word == 16'd0) begin
            zero_cnt_d = zero_cnt_q + 10'd1;
            if (zero_cnt_q == SleepLast) state_d = StSleep;
          end else begin
            zero_cnt_d = 10'd0;
          end
        end
        StSleep: begin
          // Zero words are dropped entirely; the first nonzero word wakes up.
          if (word != 16'd0) begin
            data_wr    = 1'b1;
            zero_cnt_d = 10'd0;
            state_d    = StRun;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLoadRj;
      zero_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

  // Registered write ports. Addresses advance on the edge that retires the
  // write, so each address is stable for the whole write cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rj_we             <= 1'b0;
      rj_waddr          <= '0;
      rj_wdata          <= '0;
      coeff_we          <= 1'b0;
      coeff_waddr       <= '0;
      coeff_wdata       <= '0;
      data_we           <= 1'b0;
      data_waddr        <= '0;
      data_wdata        <= '0;
      current_data_addr <= '0;
      sample_valid      <= 1'b0;
    end else begin
      rj_we        <= rj_wr;
      coeff_we     <= coeff_wr;
      data_we      <= data_wr;
      // The ALU starts only once the sample has been written to memory.
      sample_valid <= data_we;
      if (rj_wr)    rj_wdata    <= word[7:0];
      if (coeff_wr) coeff_wdata <= word;
      if (data_wr)  data_wdata  <= word;
      if (rj_we)    rj_waddr    <= rj_waddr + 4'd1;
      if (coeff_we) coeff_waddr <= coeff_waddr + 9'd1;
      if (data_we) begin
        current_data_addr <= data_waddr;
        data_waddr        <= data_waddr + 8'd1;
      end
    end
  end

  assign sleeping = (state_q == StSleep);
  assign state    = state_q;

endmodule
